fp_int_acc_seq: RTL and testbench

//  Parametrised, streaming successor to the single-shot FP-INT accumulator. Accepts a run of
//  LEN sign/exponent/fixed-point products from the FP-INT MAC, aligns each to a common exp_min,
//  and adds or subtracts it into a signed ACC_W accumulator seeded by acc_init. Emits one result
//  per run over a valid/ready handshake. Sits between the MAC product stage and writeback.

---
 rtl/fp_int_acc_seq_pkg.sv | 29 ++
 rtl/fp_int_acc_seq_if.sv | 50 +++++
 rtl/fp_int_acc_seq_align.sv | 72 +++++++
 rtl/fp_int_acc_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_int_acc_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_int_acc_seq_pkg.sv
// ============================================================================
// Package     : fp_int_pkg
// Description : Shared defaults, FSM state encoding and accumulator limit
//               constants for the streaming FP-INT accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_int_pkg;

    localparam int DEF_EXP_W  = 5;
    localparam int DEF_FRAC_W = 14;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_CNT_W  = 16;

    // Saturation limits for the default accumulator width
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_int_acc_seq_if.sv
// ============================================================================
// Interface   : fp_int_acc_seq_if
// Description : Run configuration, term stream and result handshake of the
//               streaming FP-INT accumulator.
//               master : run controller / product source / result consumer
//               slave  : fp_int_acc_seq
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_int_acc_seq_if
    import fp_int_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic [CNT_W-1:0]  cfg_len;
    logic [EXP_W-1:0]  exp_min;
    logic [ACC_W-1:0]  acc_init;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  out_exp;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic              out_unf;
    logic              busy;

    modport master (
        output start, cfg_len, exp_min, acc_init,
        output in_valid, in_sign, in_exp, in_frac, out_ready,
        input  in_ready, out_valid, out_exp, out_acc, out_ovf, out_unf, busy
    );

    modport slave (
        input  start, cfg_len, exp_min, acc_init,
        input  in_valid, in_sign, in_exp, in_frac, out_ready,
        output in_ready, out_valid, out_exp, out_acc, out_ovf, out_unf, busy
    );

endinterface

`default_nettype wire

// File: rtl/fp_int_acc_seq_align.sv
// ============================================================================
// Module      : fp_int_align
// Description : Combinational exponent-difference shifter. Aligns a term
//               magnitude to exp_min and applies its sign.
//   i_sign     : 1 = negate term
//   i_exp      : term exponent
//   i_exp_min  : alignment exponent
//   i_frac     : unsigned term magnitude
//   o_term     : signed ACC_W-bit aligned term
//   o_unf      : nonzero bits lost by right-shift alignment
//   o_ovf      : aligned magnitude exceeds the positive ACC_W range
// Config      : FP_INT_ACC_SAT_EN defined -> oversized term clamps,
//               otherwise it wraps modulo 2^ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_int_align #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = 32
) (
    input  wire logic              i_sign,
    input  wire logic [EXP_W-1:0]  i_exp,
    input  wire logic [EXP_W-1:0]  i_exp_min,
    input  wire logic [FRAC_W-1:0] i_frac,
    output logic      [ACC_W-1:0]  o_term,
    output logic                   o_unf,
    output logic                   o_ovf
);
    // Wide enough for the largest left shift and for the overflow test
    localparam int SHL_W = FRAC_W + (2**EXP_W) - 1;
    localparam int MAG_W = (SHL_W > ACC_W) ? SHL_W : ACC_W + 1;

    logic              w_left;
    logic [EXP_W-1:0]  w_shl;
    logic [EXP_W-1:0]  w_shr;
    logic [FRAC_W-1:0] w_frac_r;
    logic [MAG_W-1:0]  w_ext;
    logic [MAG_W-1:0]  w_mag;
    logic [ACC_W-1:0]  w_lo;
    logic [ACC_W-1:0]  w_signed;
    logic              w_big;

    assign w_left   = (i_exp >= i_exp_min);
    assign w_shl    = i_exp - i_exp_min;
    assign w_shr    = i_exp_min - i_exp;
    assign w_frac_r = i_frac >> w_shr;
    assign w_ext    = {{(MAG_W-FRAC_W){1'b0}}, i_frac};
    assign w_mag    = w_left ? (w_ext << w_shl) : {{(MAG_W-FRAC_W){1'b0}}, w_frac_r};

    // Shifting the truncated value back reveals whether any set bit fell off
    assign o_unf    = !w_left && ((w_frac_r << w_shr) != i_frac);

    // Magnitude >= 2^(ACC_W-1) cannot be held as a positive ACC_W value
    assign w_big    = |w_mag[MAG_W-1:ACC_W-1];
    assign o_ovf    = w_big;

    assign w_lo     = w_mag[ACC_W-1:0];
    assign w_signed = i_sign ? (~w_lo + 1'b1) : w_lo;

`ifdef FP_INT_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign o_term = w_big ? (i_sign ? SAT_MIN : SAT_MAX) : w_signed;
`else
    assign o_term = w_signed;
`endif

endmodule

`default_nettype wire

// File: rtl/fp_int_acc_seq.sv
// ============================================================================
// Module      : fp_int_acc_seq
// Description : Streaming FP-INT accumulator. A start pulse latches the run
//               length, exp_min and accumulator seed; each accepted term is
//               aligned (stage 1) and added into the accumulator (stage 2).
//               One result per run is offered on a valid/ready handshake.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : fp_int_acc_seq_if slave (config, term stream, result)
// Config      : FP_INT_ACC_SAT_EN defined -> saturating accumulation,
//               otherwise two's-complement wrap. ovf flags in both cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_int_acc_seq
    import fp_int_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fp_int_acc_seq_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [EXP_W-1:0]  r_exp_min;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_unf;

    logic              r_s1_valid;
    logic [ACC_W-1:0]  r_s1_term;
    logic              r_s1_ovf;
    logic              r_s1_unf;

    logic              w_start_ok;
    logic              w_take;
    logic              w_last;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ACC_W-1:0]  w_term;
    logic              w_term_ovf;
    logic              w_term_unf;
    logic [ACC_W:0]    w_sum;
    logic              w_sum_ovf;
    logic [ACC_W-1:0]  w_acc_nxt;

    // A new run may start from DONE in the same cycle the result is taken
    assign w_start_ok = bus.start &&
                        ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_take     = bus.in_valid && (r_state == ACC);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = w_take && (w_cnt_inc == r_len);

    fp_int_align #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_align (
        .i_sign    (bus.in_sign),
        .i_exp     (bus.in_exp),
        .i_exp_min (r_exp_min),
        .i_frac    (bus.in_frac),
        .o_term    (w_term),
        .o_unf     (w_term_unf),
        .o_ovf     (w_term_ovf)
    );

    // Stage 2 adds in ACC_W+1 bits; differing top two bits mean overflow
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + {r_s1_term[ACC_W-1], r_s1_term};
    assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef FP_INT_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign w_acc_nxt = w_sum_ovf ? (w_sum[ACC_W] ? SAT_MIN : SAT_MAX) : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (bus.cfg_len == '0) ? FLUSH : ACC;
                end
            end
            ACC: begin
                if (w_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_s1_valid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (w_start_ok) begin
                        w_state_nxt = (bus.cfg_len == '0) ? FLUSH : ACC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_exp_min  <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_term  <= '0;
            r_s1_ovf   <= 1'b0;
            r_s1_unf   <= 1'b0;
        end else begin
            r_s1_valid <= w_take;
            if (w_take) begin
                r_s1_term <= w_term;
                r_s1_ovf  <= w_term_ovf;
                r_s1_unf  <= w_term_unf;
                r_cnt     <= w_cnt_inc;
            end
            // Start only happens in IDLE/DONE, so stage 1 is empty then
            if (w_start_ok) begin
                r_len     <= bus.cfg_len;
                r_exp_min <= bus.exp_min;
                r_acc     <= bus.acc_init;
                r_ovf     <= 1'b0;
                r_unf     <= 1'b0;
                r_cnt     <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | r_s1_ovf | w_sum_ovf;
                r_unf <= r_unf | r_s1_unf;
            end
        end
    end

    assign bus.in_ready  = (r_state == ACC);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_exp   = r_exp_min;
    assign bus.out_acc   = r_acc;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_fp_int_acc_seq.sv
// ============================================================================
// Module      : tb_fp_int_acc_seq
// Description : Directed self-checking bench for fp_int_acc_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_int_acc_seq;

    logic clk;
    logic rst;

    int n_asrt;
    int n_fail;

    fp_int_acc_seq_if #(.EXP_W(5), .FRAC_W(14), .ACC_W(32), .CNT_W(16)) bus ();

    fp_int_acc_seq #(
        .EXP_W  (5),
        .FRAC_W (14),
        .ACC_W  (32),
        .CNT_W  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FP_INT_ACC_SAT_EN
    localparam logic [31:0] EXP_OVF_SUM  = 32'h7FFFFFFF;
    localparam logic [31:0] EXP_OVF_TERM = 32'h7FFFFFFF;
`else
    localparam logic [31:0] EXP_OVF_SUM  = 32'h80000000;
    localparam logic [31:0] EXP_OVF_TERM = 32'h80000000;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_asrt++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_run(input logic [15:0] len, input logic [4:0] emin, input logic [31:0] init);
        bus.start    = 1'b1;
        bus.cfg_len  = len;
        bus.exp_min  = emin;
        bus.acc_init = init;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic send(input logic s, input logic [4:0] e, input logic [13:0] f);
        int k;
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_frac  = f;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            step();
            k++;
        end
        if (k == 20) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            step();
            k++;
        end
        chk(tag, {63'd0, bus.out_valid}, 64'd1);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("out_valid_after_handshake", {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.exp_min   = '0;
        bus.acc_init  = '0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        chk("rst_busy",      {63'd0, bus.busy},      64'd0);
        chk("rst_out_acc",   {32'd0, bus.out_acc},   64'd0);
        chk("rst_out_exp",   {59'd0, bus.out_exp},   64'd0);
        chk("rst_ovf_unf",   {62'd0, bus.out_ovf, bus.out_unf}, 64'd0);

        // Single term, exact latency: 3<<2 + 1 = 13
        start_run(16'd1, 5'd16, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 5'd18;
        bus.in_frac  = 14'd3;
        chk("t1_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("t1_busy",     {63'd0, bus.busy},     64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t1_valid_p1", {63'd0, bus.out_valid}, 64'd0);
        chk("t1_in_ready_flush", {63'd0, bus.in_ready}, 64'd0);
        step();
        chk("t1_valid_p2", {63'd0, bus.out_valid}, 64'd0);
        step();
        chk("t1_valid_p3", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_acc", {32'd0, bus.out_acc}, 64'd13);
        chk("t1_exp", {59'd0, bus.out_exp}, 64'd16);
        chk("t1_flags", {62'd0, bus.out_ovf, bus.out_unf}, 64'd0);
        consume();
        chk("t1_busy_idle", {63'd0, bus.busy}, 64'd0);

        // Mixed add/subtract: 5 - 6 + 7 - 16 = -10
        start_run(16'd4, 5'd16, 32'd0);
        send(1'b0, 5'd16, 14'd5);
        send(1'b1, 5'd17, 14'd3);
        send(1'b0, 5'd16, 14'd7);
        send(1'b1, 5'd20, 14'd1);
        wait_out("t2_valid");
        chk("t2_acc", {32'd0, bus.out_acc}, 64'h00000000FFFFFFF6);
        chk("t2_flags", {62'd0, bus.out_ovf, bus.out_unf}, 64'd0);

        // Back-to-back start in the handshake cycle; right-shift with loss
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_len   = 16'd2;
        bus.exp_min   = 5'd16;
        bus.acc_init  = 32'd0;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("t3_nobubble_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t3_nobubble_ready", {63'd0, bus.in_ready},  64'd1);
        send(1'b0, 5'd15, 14'd3);
        send(1'b0, 5'd15, 14'd4);
        wait_out("t3_valid");
        chk("t3_acc", {32'd0, bus.out_acc}, 64'd3);
        chk("t3_unf", {63'd0, bus.out_unf}, 64'd1);
        chk("t3_ovf", {63'd0, bus.out_ovf}, 64'd0);
        consume();
        start_run(16'd1, 5'd16, 32'd0);
        send(1'b0, 5'd16, 14'd2);
        wait_out("t3b_valid");
        chk("t3b_acc", {32'd0, bus.out_acc}, 64'd2);
        chk("t3b_unf_cleared", {63'd0, bus.out_unf}, 64'd0);
        consume();

        // Sum overflow
        start_run(16'd1, 5'd16, 32'h7FFFFFFF);
        send(1'b0, 5'd16, 14'd1);
        wait_out("t4_valid");
        chk("t4_acc", {32'd0, bus.out_acc}, {32'd0, EXP_OVF_SUM});
        chk("t4_ovf", {63'd0, bus.out_ovf}, 64'd1);
        consume();

        // Term overflow: 0x3FFF << 31
        start_run(16'd1, 5'd0, 32'd0);
        send(1'b0, 5'd31, 14'h3FFF);
        wait_out("t4b_valid");
        chk("t4b_acc", {32'd0, bus.out_acc}, {32'd0, EXP_OVF_TERM});
        chk("t4b_ovf", {63'd0, bus.out_ovf}, 64'd1);
        consume();

        // Back-pressure: result held, start ignored
        start_run(16'd1, 5'd16, 32'd5);
        send(1'b0, 5'd16, 14'd1);
        wait_out("t5_valid");
        bus.start    = 1'b1;
        bus.cfg_len  = 16'd0;
        bus.exp_min  = 5'd3;
        bus.acc_init = 32'd99;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("t5_hold_acc",   {32'd0, bus.out_acc},   64'd6);
            chk("t5_hold_exp",   {59'd0, bus.out_exp},   64'd16);
            chk("t5_hold_ready", {63'd0, bus.in_ready},  64'd0);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        consume();
        chk("t5_idle_busy", {63'd0, bus.busy}, 64'd0);

        // Zero-length run
        start_run(16'd0, 5'd7, 32'h12345678);
        chk("t5_len0_valid_p0", {63'd0, bus.out_valid}, 64'd0);
        step();
        chk("t5_len0_valid_p1", {63'd0, bus.out_valid}, 64'd1);
        chk("t5_len0_acc", {32'd0, bus.out_acc}, 64'h0000000012345678);
        chk("t5_len0_exp", {59'd0, bus.out_exp}, 64'd7);
        consume();

        // Reset mid-run
        start_run(16'd4, 5'd16, 32'd0);
        send(1'b0, 5'd16, 14'd5);
        send(1'b0, 5'd16, 14'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_ready", {63'd0, bus.in_ready},  64'd0);
        chk("t6_busy",  {63'd0, bus.busy},      64'd0);
        chk("t6_acc",   {32'd0, bus.out_acc},   64'd0);
        chk("t6_exp",   {59'd0, bus.out_exp},   64'd0);
        chk("t6_flags", {62'd0, bus.out_ovf, bus.out_unf}, 64'd0);
        step();
        chk("t6_acc_settled", {32'd0, bus.out_acc}, 64'd0);
        start_run(16'd1, 5'd16, 32'd1);
        send(1'b0, 5'd18, 14'd3);
        wait_out("t6_rerun_valid");
        chk("t6_rerun_acc", {32'd0, bus.out_acc}, 64'd13);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
